// File: rtl/lattice_block_multi.sv
// lattice_block_multi: delays the job bus PIPE_STAGES cycles and merges per-core hits (round-robin over one-entry slots) into the chained result bus; clk/rst, in_*/out_* job bus, core_hit/core_nonce, res_in_*/res_out_*, pending, overflow
module lattice_block_multi #(
  parameter int DATA_W      = 608,
  parameter int NONCE_W     = 32,
  parameter int NUM_CORES   = 4,
  parameter int LOG2_TOTAL  = 4,
  parameter int INDEX       = 0,
  parameter int PIPE_STAGES = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic                           in_new_job,
  input  logic [DATA_W-1:0]              in_data,
  output logic                           out_valid,
  output logic                           out_new_job,
  output logic [DATA_W-1:0]              out_data,
  input  logic [NUM_CORES-1:0]           core_hit,
  input  logic [NUM_CORES*NONCE_W-1:0]   core_nonce,
  input  logic                           res_in_valid,
  input  logic [NONCE_W-1:0]             res_in_nonce,
  input  logic [LOG2_TOTAL-1:0]          res_in_id,
  output logic                           res_out_valid,
  output logic [NONCE_W-1:0]             res_out_nonce,
  output logic [LOG2_TOTAL-1:0]          res_out_id,
  output logic [NUM_CORES-1:0]           pending,
  output logic                           overflow
);
  localparam int IW = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;
  localparam int BASE = INDEX * NUM_CORES;
  if (BASE + NUM_CORES > 2 ** LOG2_TOTAL) begin : g_id_check
    $error("lattice_block_multi: global core id does not fit in LOG2_TOTAL bits");
  end
  logic              vld [PIPE_STAGES];
  logic              nj  [PIPE_STAGES];
  logic [DATA_W-1:0] dat [PIPE_STAGES];
  logic [NONCE_W-1:0] slot [NUM_CORES];
  logic [IW-1:0] ptr, sel, nxt;
  logic drain, flush;
  assign out_valid   = vld[PIPE_STAGES-1];
  assign out_new_job = nj[PIPE_STAGES-1];
  assign out_data    = dat[PIPE_STAGES-1];
  assign drain = !res_in_valid && |pending;
  assign flush = in_valid && in_new_job;
  assign nxt   = IW'((int'(sel) + 1) % NUM_CORES);
  always_comb begin
    sel = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--)
      if (pending[(int'(ptr) + k) % NUM_CORES]) sel = IW'((int'(ptr) + k) % NUM_CORES);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < PIPE_STAGES; s++) begin
        vld[s] <= 1'b0;
        nj[s]  <= 1'b0;
        dat[s] <= '0;
      end
    end else begin
      vld[0] <= in_valid;
      nj[0]  <= flush;
      dat[0] <= in_data;
      for (int s = 1; s < PIPE_STAGES; s++) begin
        vld[s] <= vld[s-1];
        nj[s]  <= nj[s-1];
        dat[s] <= dat[s-1];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      res_out_valid <= 1'b0;
      res_out_nonce <= '0;
      res_out_id    <= '0;
      pending       <= '0;
      overflow      <= 1'b0;
      ptr           <= '0;
      for (int i = 0; i < NUM_CORES; i++) slot[i] <= '0;
    end else begin
      res_out_valid <= res_in_valid || drain;
      if (res_in_valid) begin
        res_out_nonce <= res_in_nonce;
        res_out_id    <= res_in_id;
      end else if (drain) begin
        res_out_nonce <= slot[sel];
        res_out_id    <= LOG2_TOTAL'(BASE + int'(sel));
        ptr           <= nxt;
      end
      // a slot draining this cycle counts as free, so a same-cycle hit refills it
      for (int i = 0; i < NUM_CORES; i++) begin
        if (flush) pending[i] <= 1'b0;
        else if (core_hit[i] && (!pending[i] || (drain && int'(sel) == i))) begin
          slot[i]    <= core_nonce[i*NONCE_W +: NONCE_W];
          pending[i] <= 1'b1;
        end else if (core_hit[i]) overflow <= 1'b1;
        else if (drain && int'(sel) == i) pending[i] <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_lattice_block_multi.sv
// tb_lattice_block_multi: directed bench with a result scoreboard for lattice_block_multi
module tb_lattice_block_multi;
  localparam int DW = 608, NW = 32, NC = 4, IDW = 4, IDX = 2, PS = 2;
  logic clk = 1'b0, rst;
  logic in_valid, in_new_job, out_valid, out_new_job;
  logic [DW-1:0] in_data, out_data, pat;
  logic [NC-1:0] core_hit, pending;
  logic [NC*NW-1:0] core_nonce;
  logic res_in_valid, res_out_valid, overflow;
  logic [NW-1:0] res_in_nonce, res_out_nonce;
  logic [IDW-1:0] res_in_id, res_out_id;
  logic [35:0] q[$];
  logic [35:0] exp_r;
  int compared = 0, mismatched = 0;
  always #5 clk = ~clk;
  lattice_block_multi #(.DATA_W(DW), .NONCE_W(NW), .NUM_CORES(NC), .LOG2_TOTAL(IDW),
                        .INDEX(IDX), .PIPE_STAGES(PS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_new_job(in_new_job), .in_data(in_data),
    .out_valid(out_valid), .out_new_job(out_new_job), .out_data(out_data),
    .core_hit(core_hit), .core_nonce(core_nonce), .res_in_valid(res_in_valid),
    .res_in_nonce(res_in_nonce), .res_in_id(res_in_id), .res_out_valid(res_out_valid),
    .res_out_nonce(res_out_nonce), .res_out_id(res_out_id), .pending(pending), .overflow(overflow));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  always @(posedge clk) begin
    #2;
    if (res_out_valid) begin
      chk("sb_expected", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) begin
        exp_r = q.pop_front();
        chk("res_nonce", 64'(res_out_nonce), 64'(exp_r[31:0]));
        chk("res_id", 64'(res_out_id), 64'(exp_r[35:32]));
      end
    end
  end
  initial begin
    pat = {76{8'hA5}};
    rst = 1'b1; in_valid = 1'b1; in_new_job = 1'b0; in_data = pat;
    core_hit = '0; core_nonce = '0; res_in_valid = 1'b0; res_in_nonce = '0; res_in_id = '0;
    repeat (3) tick();
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_data_zero", 64'(out_data == '0), 1);
    chk("rst_res_valid", 64'(res_out_valid), 0);
    chk("rst_res_nonce", 64'(res_out_nonce), 0);
    chk("rst_pending", 64'(pending), 0);
    chk("rst_overflow", 64'(overflow), 0);
    rst = 1'b0; in_new_job = 1'b1;
    tick();
    in_valid = 1'b0; in_new_job = 1'b0; in_data = '0;
    chk("pipe_early", 64'(out_valid), 0);
    tick();
    chk("pipe_valid", 64'(out_valid), 1);
    chk("pipe_new_job", 64'(out_new_job), 1);
    compared++;
    assert (out_data === pat) else begin
      mismatched++;
      $error("FAIL pipe_data observed=%0h expected=%0h", out_data[31:0], pat[31:0]);
    end
    in_new_job = 1'b1;
    tick();
    in_new_job = 1'b0;
    chk("pipe_drop", 64'(out_valid), 0);
    tick();
    chk("nj_gated", 64'(out_new_job), 0);
    core_hit = 4'b0100; core_nonce[2*NW +: NW] = 32'h1234_5678;
    q.push_back({4'd10, 32'h1234_5678});
    tick();
    core_hit = '0;
    chk("t2_pending", 64'(pending), 64'h4);
    chk("t2_no_early", 64'(res_out_valid), 0);
    tick();
    chk("t2_valid", 64'(res_out_valid), 1);
    chk("t2_drained", 64'(pending), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NC; i++) begin
      core_nonce[i*NW +: NW] = 32'hC0DE_0000 + 32'(i);
      q.push_back({4'(8 + i), 32'hC0DE_0000 + 32'(i)});
    end
    core_hit = 4'b1111;
    tick();
    core_hit = '0;
    chk("t3_pending", 64'(pending), 64'hF);
    repeat (4) tick();
    chk("t3_empty", 64'(pending), 0);
    core_hit = 4'b1001;
    q.push_back({4'd8, 32'hC0DE_0000});
    q.push_back({4'd11, 32'hC0DE_0003});
    tick();
    core_hit = '0;
    repeat (2) tick();
    core_hit = 4'b0010; core_nonce[NW +: NW] = 32'hAAAA_0001;
    tick();
    for (int k = 0; k < 5; k++) begin
      res_in_valid = 1'b1; res_in_nonce = 32'h5500_0000 + 32'(k); res_in_id = 4'(k + 1);
      q.push_back({4'(k + 1), 32'h5500_0000 + 32'(k)});
      core_hit = k == 0 ? 4'b0010 : 4'b0000;
      core_nonce[NW +: NW] = 32'hBBBB_0002;
      tick();
    end
    res_in_valid = 1'b0; core_hit = '0;
    chk("t4_overflow", 64'(overflow), 1);
    chk("t4_pending", 64'(pending), 64'h2);
    q.push_back({4'd9, 32'hAAAA_0001});
    tick();
    chk("t4_local_out", 64'(res_out_valid), 1);
    chk("t4_drained", 64'(pending), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_clears_overflow", 64'(overflow), 0);
    core_hit = 4'b1001; res_in_valid = 1'b1; res_in_nonce = 32'h6600_0001; res_in_id = 4'd3;
    q.push_back({4'd3, 32'h6600_0001});
    tick();
    core_hit = 4'b0010; in_valid = 1'b1; in_new_job = 1'b1;
    res_in_nonce = 32'h6600_0002; res_in_id = 4'd4;
    q.push_back({4'd4, 32'h6600_0002});
    chk("t5_pre_pending", 64'(pending), 64'h9);
    tick();
    core_hit = '0; in_valid = 1'b0; in_new_job = 1'b0; res_in_valid = 1'b0;
    chk("t5_flushed", 64'(pending), 0);
    chk("t5_no_overflow", 64'(overflow), 0);
    repeat (2) tick();
    chk("t5_still_empty", 64'(pending), 0);
    core_hit = 4'b0111; res_in_valid = 1'b1; res_in_nonce = 32'h7700_0001; res_in_id = 4'd5;
    in_valid = 1'b1; in_data = pat;
    q.push_back({4'd5, 32'h7700_0001});
    tick();
    core_hit = '0; res_in_valid = 1'b0; in_valid = 1'b0; in_data = '0; rst = 1'b1;
    chk("t6_pre_pending", 64'(pending), 64'h7);
    tick();
    rst = 1'b0;
    chk("t6_pending", 64'(pending), 0);
    chk("t6_out_valid", 64'(out_valid), 0);
    chk("t6_res_valid", 64'(res_out_valid), 0);
    repeat (3) tick();
    chk("t6_pipe_clean", 64'(out_valid), 0);
    chk("t6_no_stale", 64'(res_out_valid), 0);
    core_hit = 4'b0001; core_nonce[0 +: NW] = 32'hD00D_0001;
    q.push_back({4'd8, 32'hD00D_0001});
    tick();
    core_nonce[0 +: NW] = 32'hD00D_0002;
    q.push_back({4'd8, 32'hD00D_0002});
    tick();
    core_hit = '0;
    chk("refill_pending", 64'(pending), 64'h1);
    chk("refill_no_overflow", 64'(overflow), 0);
    tick();
    chk("refill_drained", 64'(pending), 0);
    repeat (2) tick();
    chk("sb_drained", 64'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
